// File: rtl/clk_divider_pkg.sv
// Shared constants and sizing helpers for the clk_divider square-wave generators.
// Default frequencies match the 40 MHz fitness-timer board.
package clk_divider_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 40_000_000;
    localparam int DEFAULT_F_SLOW_HZ   = 1;
    localparam int DEFAULT_F_500_HZ    = 500;
    localparam int DEFAULT_F_1K_HZ     = 1000;
    localparam int DEFAULT_F_2K_HZ     = 2000;

    // Input cycles per half period; a non-positive frequency yields 0 so the
    // caller's range check can reject it instead of dividing by zero.
    function automatic int half_count(input int clk_hz, input int f_hz);
        if (f_hz <= 0) begin
            return 0;
        end
        return clk_hz / (2 * f_hz);
    endfunction

    // Counter width for values 0..half-1, never narrower than one bit.
    function automatic int cnt_width(input int half);
        if (half <= 2) begin
            return 1;
        end
        return $clog2(half);
    endfunction

endpackage

// File: rtl/clk_div_toggle.sv
// One free-running divide-by-2*HALF square-wave generator with synchronous active-low reset.
// Build option CLKDIV_TICK_EN adds a one-cycle pulse marking each rising edge of clk_out.
module clk_div_toggle
    import clk_divider_pkg::*;
#(
    parameter int HALF = 10
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_out
`ifdef CLKDIV_TICK_EN
    ,
    output logic tick
`endif
);

    localparam int            W    = cnt_width(HALF);
    localparam logic [W-1:0]  LAST = W'(HALF - 1);

    if (HALF < 1) begin : g_bad_half
        $error("clk_div_toggle: HALF must be at least 1");
    end

    logic [W-1:0] cnt;
    logic         at_last;

    assign at_last = (cnt == LAST);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (at_last) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + W'(1);
        end
    end

`ifdef CLKDIV_TICK_EN
    // Registered alongside the 0->1 toggle, so the pulse sits in the first high cycle.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            tick <= 1'b0;
        end else begin
            tick <= at_last && !clk_out;
        end
    end
`endif

endmodule

// File: rtl/clk_divider.sv
// Four independent 50%-duty square waves (1 Hz, 500 Hz, 1 kHz, 2 kHz) derived from clk_in.
// Define CLKDIV_TICK_EN to add the tick_* rising-edge pulse outputs.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int F_SLOW_HZ   = DEFAULT_F_SLOW_HZ,
    parameter int F_500_HZ    = DEFAULT_F_500_HZ,
    parameter int F_1K_HZ     = DEFAULT_F_1K_HZ,
    parameter int F_2K_HZ     = DEFAULT_F_2K_HZ
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_1Hz,
    output logic clk_500Hz,
    output logic clk_1kHz,
    output logic clk_2kHz
`ifdef CLKDIV_TICK_EN
    ,
    output logic tick_1Hz,
    output logic tick_500Hz,
    output logic tick_1kHz,
    output logic tick_2kHz
`endif
);

    localparam int HALF_1HZ   = half_count(CLK_FREQ_HZ, F_SLOW_HZ);
    localparam int HALF_500HZ = half_count(CLK_FREQ_HZ, F_500_HZ);
    localparam int HALF_1KHZ  = half_count(CLK_FREQ_HZ, F_1K_HZ);
    localparam int HALF_2KHZ  = half_count(CLK_FREQ_HZ, F_2K_HZ);

    if (HALF_1HZ < 1 || HALF_500HZ < 1 || HALF_1KHZ < 1 || HALF_2KHZ < 1) begin : g_bad_freq
        $error("clk_divider: every output frequency must be at most CLK_FREQ_HZ/2");
    end

    clk_div_toggle #(.HALF(HALF_1HZ)) u_div_1hz (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_out (clk_1Hz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick_1Hz)
`endif
    );

    clk_div_toggle #(.HALF(HALF_500HZ)) u_div_500hz (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_out (clk_500Hz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick_500Hz)
`endif
    );

    clk_div_toggle #(.HALF(HALF_1KHZ)) u_div_1khz (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_out (clk_1kHz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick_1kHz)
`endif
    );

    clk_div_toggle #(.HALF(HALF_2KHZ)) u_div_2khz (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_out (clk_2kHz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick_2kHz)
`endif
    );

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: a scaled instance (HALF 20000/40/20/10) and a default 40 MHz instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clk_divider;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_b = 1'b0;

    logic a_1hz, a_500hz, a_1khz, a_2khz;
    logic b_1hz, b_500hz, b_1khz, b_2khz;
`ifdef CLKDIV_TICK_EN
    logic a_t1hz, a_t500hz, a_t1khz, a_t2khz;
    logic b_t1hz, b_t500hz, b_t1khz, b_t2khz;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_divider #(
        .CLK_FREQ_HZ (40_000),
        .F_SLOW_HZ   (1),
        .F_500_HZ    (500),
        .F_1K_HZ     (1000),
        .F_2K_HZ     (2000)
    ) u_dut_a (
        .clk_in    (clk),
        .reset     (reset),
        .clk_1Hz   (a_1hz),
        .clk_500Hz (a_500hz),
        .clk_1kHz  (a_1khz),
        .clk_2kHz  (a_2khz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick_1Hz   (a_t1hz),
        .tick_500Hz (a_t500hz),
        .tick_1kHz  (a_t1khz),
        .tick_2kHz  (a_t2khz)
`endif
    );

    clk_divider u_dut_b (
        .clk_in    (clk),
        .reset     (reset_b),
        .clk_1Hz   (b_1hz),
        .clk_500Hz (b_500hz),
        .clk_1kHz  (b_1khz),
        .clk_2kHz  (b_2khz)
`ifdef CLKDIV_TICK_EN
        ,
        .tick_1Hz   (b_t1hz),
        .tick_500Hz (b_t500hz),
        .tick_1kHz  (b_t1khz),
        .tick_2kHz  (b_t2khz)
`endif
    );

    // Bit order {1Hz, 500Hz, 1kHz, 2kHz}.
    function automatic logic [3:0] outsA();
        return {a_1hz, a_500hz, a_1khz, a_2khz};
    endfunction

    // Drive reset for the scaled instance, then let the given number of rising edges pass.
    task automatic applyStimulus(input logic rst_n, input int cycles);
        reset = rst_n;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Samples right after each edge; every completed high/low run must be exactly HALF long.
    task automatic measureDuty(input int n);
        int   halfs[4];
        int   run_len[4];
        logic prev[4];
        logic [3:0] cur;
        halfs = '{10, 20, 40, 20000};
        for (int i = 0; i < 4; i++) begin
            run_len[i] = 1;
            prev[i]    = 1'b0;
        end
        for (int c = 1; c <= n; c++) begin
            applyStimulus(1'b1, 1);
            cur = outsA();
`ifdef CLKDIV_TICK_EN
            checkOutput($sformatf("tick_2k_c%0d", c), int'(a_t2khz), int'(cur[0] && !prev[0]));
`endif
            for (int i = 0; i < 4; i++) begin
                if (cur[i] == prev[i]) begin
                    run_len[i]++;
                end else begin
                    checkOutput($sformatf("duty_bit%0d_c%0d", i, c), run_len[i], halfs[i]);
                    run_len[i] = 1;
                    prev[i]    = cur[i];
                end
            end
        end
    endtask

    typedef struct {
        logic       rst_n;
        int         cycles;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int rises;
        int first_rise;
        int second_rise;
        int high_1hz;
        logic prev_2k;

        // Expected values: out = (edges since release / HALF) % 2.
        vecs[0] = '{1'b0,  3, 4'b0000, "hold_reset"};
        vecs[1] = '{1'b1,  9, 4'b0000, "k9"};
        vecs[2] = '{1'b1,  1, 4'b0001, "k10_2k_rise"};
        vecs[3] = '{1'b1,  9, 4'b0001, "k19"};
        vecs[4] = '{1'b1,  1, 4'b0010, "k20_1k_rise"};
        vecs[5] = '{1'b1, 10, 4'b0011, "k30"};
        vecs[6] = '{1'b1, 10, 4'b0100, "k40_500_rise"};
        vecs[7] = '{1'b1, 25, 4'b0110, "k65"};
        vecs[8] = '{1'b1, 15, 4'b0000, "k80"};
        vecs[9] = '{1'b1, 15, 4'b0001, "k95"};

        @(negedge clk);
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].rst_n, vecs[v].cycles);
            checkOutput(vecs[v].name, int'(outsA()), int'(vecs[v].exp));
`ifdef CLKDIV_TICK_EN
            if (!vecs[v].rst_n) begin
                checkOutput("tick_in_reset", int'({a_t1hz, a_t500hz, a_t1khz, a_t2khz}), 0);
            end
`endif
        end

        // 50% duty over 400 cycles from a fresh reset.
        applyStimulus(1'b0, 1);
        checkOutput("duty_reset", int'(outsA()), 0);
        measureDuty(400);

        // Reset pulse mid-period while clk_2kHz is high.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 15);
        checkOutput("k15_2k_high", int'(outsA()), 4'b0001);
        applyStimulus(1'b0, 1);
        checkOutput("midreset_zero", int'(outsA()), 0);
        applyStimulus(1'b1, 9);
        checkOutput("post_reset_k9", int'(outsA()), 0);
        applyStimulus(1'b1, 1);
        checkOutput("post_reset_k10", int'(outsA()), 4'b0001);

        // Slow output first rises after 20000 edges.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 19999);
        checkOutput("1hz_k19999", int'(a_1hz), 0);
        applyStimulus(1'b1, 1);
        checkOutput("1hz_k20000", int'(a_1hz), 1);

        // Default 40 MHz instance over 1 ms: clk_2kHz rises at 10000 and 30000.
        rises = 0;
        first_rise = -1;
        second_rise = -1;
        high_1hz = 0;
        prev_2k = b_2khz;
        checkOutput("b_reset_2k", int'(b_2khz), 0);
        reset_b = 1'b1;
        for (int c = 1; c <= 40000; c++) begin
            @(negedge clk);
            if (b_2khz && !prev_2k) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            prev_2k = b_2khz;
            if (b_1hz) high_1hz++;
        end
        checkOutput("b_2k_rises", rises, 2);
        checkOutput("b_2k_first_rise", first_rise, 10000);
        checkOutput("b_2k_period", second_rise - first_rise, 20000);
        checkOutput("b_2k_end", int'(b_2khz), 0);
        checkOutput("b_1hz_high_cycles", high_1hz, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
